swa_weight_ctrl: RTL and testbench
==================================

# swa_weight_ctrl

Per-port weight sequencer for the weighted round-robin (WRRA) switch allocator. It counts switch-allocation grants per input VC and per input port against configured weights. It generates the `vc_weight_is_consumed_all` and `iport_weight_is_consumed_all` signals that the combined VC/SW allocator uses to rotate WRRA priority. It sits beside the allocator in each router, fed by the allocator's grant outputs and feeding its weight inputs the following cycle.

## Interface
Parameters:
- `V`, 4: VCs per port
- `P`, 5: ports per router
- `WEIGHTw`, 4: weight field width; max weight 2^WEIGHTw-1

Ports:
- `clk` in 1: router clock
- `reset` in 1: asynchronous, active-low (0 = reset asserted)
- `weight_cfg_all` in P*WEIGHTw: per-input-port weight; port i at bits [i*WEIGHTw +: WEIGHTw]
- `ivc_request_all` in PV: per-IVC switch request
- `ivc_num_getting_sw_grant` in PV: one-hot-per-port SW grant from allocator
- `any_ivc_sw_request_granted_all` in P: port i won a crossbar output this cycle
- `ivc_tail_granted_all` in PV: granted flit of IVC is a tail (or single-flit packet)
- `vc_weight_is_consumed_all` out PV: registered, one-cycle pulse per IVC
- `iport_weight_is_consumed_all` out P: registered, one-cycle pulse per port
- `port_weight_q_all` out P*WEIGHTw: latched weight of current round (debug/observation)

## Operation
- Effective weight W_eff = weight_cfg, except 0 is treated as 1.
- Per port i: round register `wq[i]` and grant counter `pcnt[i]` (WEIGHTw bits). Per IVC: `vcnt[i*V+v]` (WEIGHTw bits).
- Port states: IDLE (pcnt=0, no round open) and ACTIVE.
- IDLE -> ACTIVE on the first grant to port i. `wq[i]` latches W_eff in that same cycle. Mid-round changes to `weight_cfg_all` take effect only at the next round start.
- In ACTIVE, each cycle with `any_ivc_sw_request_granted_all[i]=1` increments `pcnt[i]`.
- When the grant would make pcnt == wq: pulse `iport_weight_is_consumed_all[i]`, clear pcnt, return to IDLE.
- wq=1: consumed on every grant, and the port stays effectively in IDLE.
- Per IVC: a grant increments vcnt. When vcnt reaches wq[i], or `ivc_tail_granted_all` is set with the grant: pulse `vc_weight_is_consumed_all` for that IVC and clear vcnt.
- Idle clear: if every `ivc_request_all` bit of port i is 0 and there is no grant that cycle, pcnt[i] and all V vcnt of port i clear to 0 and the port goes IDLE. No pulse is emitted.
- Precedence within a cycle: grant-completion (pulse + clear) > idle clear > increment.
- A grant that is not one-hot within a port is a protocol violation; simulation-only assertion.
- Reset (async, any time including mid-round): all counters, wq, and outputs go to 0, all ports IDLE.
- Reset values of all outputs: `vc_weight_is_consumed_all`=0, `iport_weight_is_consumed_all`=0, `port_weight_q_all`=0.

## Timing
- All outputs are registered. Pulses appear exactly 1 cycle after the completing grant cycle and last 1 cycle.
- Back-to-back completions produce back-to-back pulses.
- Counter arithmetic is WEIGHTw wide. A counter never exceeds wq-1 because completion clears it, so no wrap occurs.
- No handshake: grant inputs are sampled every cycle.
- Reset deassertion is synchronous to `clk` at the source; the block adds no synchronizer.
- Combinational input-to-output paths: none.

## Structure
- Shared package/header holds the derived constants (PV = P*V, WEIGHTw default) and the weight-0-as-1 function, used by this block and the WRRA arbiter.
- One sub-module, `swa_weight_port`: one input port's wq, pcnt, V vcnts, IDLE/ACTIVE state and output flops.
- Top level generates P instances and slices the buses. Top level holds no logic beyond slicing.

## Test plan
- Port 0 weight 3, IVC0 requests and is granted every cycle: `iport_weight_is_consumed_all[0]` pulses on cycles 3, 6, 9 (1-cycle lag after the 3rd, 6th, 9th grant); `vc_weight_is_consumed_all[0]` pulses on the same cycles.
- Weight 0 on port 2 with continuous grants: a port pulse follows every grant cycle.
- Port 1 weight 4, IVC1 tail granted on its 2nd grant: a VC pulse follows that grant and vcnt clears. The port pulse still comes only after the 4th port grant.
- Weight changed 3->5 after the 1st grant of a round: the current round completes at 3 grants, the next round at 5. `port_weight_q_all` shows 3, then 5.
- Port 3 weight 4: 2 grants, then `ivc_request_all` for port 3 drops to 0 for 1 cycle. Counters clear with no pulse, and the next round needs 4 fresh grants.
- Reset asserted (low) mid-round after 2 of 4 grants: all outputs 0 immediately and asynchronously. After release, 4 grants are required before the next pulse.

Source files
------------

// File: rtl/swa_weight_ctrl_pkg.sv
// Shared constants and the weight-0-as-1 rule for the WRRA weight sequencer and arbiter.
package swa_weight_ctrl_pkg;

  localparam int SWA_V       = 4;
  localparam int SWA_P       = 5;
  localparam int SWA_PV      = SWA_P * SWA_V;
  localparam int SWA_WEIGHTW = 4;
  localparam int SWA_WMAX    = 8;

  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } port_state_e;

  // Callers zero-extend their weight into SWA_WMAX bits and truncate the result back.
  function automatic logic [SWA_WMAX-1:0] weight_eff(input logic [SWA_WMAX-1:0] w);
    return (w == '0) ? SWA_WMAX'(1) : w;
  endfunction

endpackage

// File: rtl/swa_weight_port.sv
// One input port's weight round: latched weight, port grant counter, per-VC counters.
// Consumed pulses are registered and appear one cycle after the completing grant.
module swa_weight_port
  import swa_weight_ctrl_pkg::*;
#(
  parameter int V       = SWA_V,
  parameter int WEIGHTw = SWA_WEIGHTW
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [WEIGHTw-1:0] weight_cfg_i,
  input  logic [V-1:0]       ivc_request_i,
  input  logic [V-1:0]       ivc_grant_i,
  input  logic               port_grant_i,
  input  logic [V-1:0]       ivc_tail_i,
  output logic [V-1:0]       vc_consumed_o,
  output logic               port_consumed_o,
  output logic [WEIGHTw-1:0] port_weight_o
);

  port_state_e                  state_q;
  logic [WEIGHTw-1:0]           wq_q;
  logic [WEIGHTw-1:0]           pcnt_q;
  logic [V-1:0][WEIGHTw-1:0]    vcnt_q;
  logic [V-1:0]                 vc_pulse_q;
  logic                         port_pulse_q;

  logic [WEIGHTw-1:0]           w_eff;
  logic [WEIGHTw-1:0]           round_w_d;
  logic [WEIGHTw:0]             pcnt_d;
  logic [V-1:0][WEIGHTw:0]      vcnt_d;

  assign w_eff = WEIGHTw'(weight_eff(SWA_WMAX'(weight_cfg_i)));

  // A grant that opens a round is judged against the weight it latches.
  always_comb begin
    round_w_d = (state_q == PS_IDLE) ? w_eff : wq_q;
    pcnt_d    = {1'b0, pcnt_q} + (WEIGHTw+1)'(1);
    for (int v = 0; v < V; v++) begin
      vcnt_d[v] = {1'b0, vcnt_q[v]} + (WEIGHTw+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= PS_IDLE;
      wq_q         <= '0;
      pcnt_q       <= '0;
      vcnt_q       <= '0;
      vc_pulse_q   <= '0;
      port_pulse_q <= 1'b0;
    end else begin
      vc_pulse_q   <= '0;
      port_pulse_q <= 1'b0;
      if (port_grant_i) begin
        if (state_q == PS_IDLE) begin
          wq_q <= w_eff;
        end
        if (pcnt_d >= {1'b0, round_w_d}) begin
          port_pulse_q <= 1'b1;
          pcnt_q       <= '0;
          state_q      <= PS_IDLE;
        end else begin
          pcnt_q  <= pcnt_d[WEIGHTw-1:0];
          state_q <= PS_ACTIVE;
        end
        for (int v = 0; v < V; v++) begin
          if (ivc_grant_i[v]) begin
            if (ivc_tail_i[v] || (vcnt_d[v] >= {1'b0, round_w_d})) begin
              vc_pulse_q[v] <= 1'b1;
              vcnt_q[v]     <= '0;
            end else begin
              vcnt_q[v] <= vcnt_d[v][WEIGHTw-1:0];
            end
          end
        end
      end else if (ivc_request_i == '0) begin
        pcnt_q  <= '0;
        vcnt_q  <= '0;
        state_q <= PS_IDLE;
      end
    end
  end

  grant_onehot_a: assert property (@(posedge clk_i) disable iff (!reset_ni) $onehot0(ivc_grant_i));

  assign vc_consumed_o   = vc_pulse_q;
  assign port_consumed_o = port_pulse_q;
  assign port_weight_o   = wq_q;

endmodule

// File: rtl/swa_weight_ctrl.sv
// Per-router WRRA weight sequencer: one swa_weight_port per input port, buses sliced here.
// All outputs registered; no handshake, grants sampled every cycle.
module swa_weight_ctrl
  import swa_weight_ctrl_pkg::*;
#(
  parameter int V       = SWA_V,
  parameter int P       = SWA_P,
  parameter int WEIGHTw = SWA_WEIGHTW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [P*WEIGHTw-1:0] weight_cfg_all,
  input  logic [P*V-1:0]       ivc_request_all,
  input  logic [P*V-1:0]       ivc_num_getting_sw_grant,
  input  logic [P-1:0]         any_ivc_sw_request_granted_all,
  input  logic [P*V-1:0]       ivc_tail_granted_all,
  output logic [P*V-1:0]       vc_weight_is_consumed_all,
  output logic [P-1:0]         iport_weight_is_consumed_all,
  output logic [P*WEIGHTw-1:0] port_weight_q_all
);

  for (genvar gp = 0; gp < P; gp++) begin : g_port
    swa_weight_port #(
      .V       (V),
      .WEIGHTw (WEIGHTw)
    ) u_port (
      .clk_i           (clk),
      .reset_ni        (reset),
      .weight_cfg_i    (weight_cfg_all[gp*WEIGHTw +: WEIGHTw]),
      .ivc_request_i   (ivc_request_all[gp*V +: V]),
      .ivc_grant_i     (ivc_num_getting_sw_grant[gp*V +: V]),
      .port_grant_i    (any_ivc_sw_request_granted_all[gp]),
      .ivc_tail_i      (ivc_tail_granted_all[gp*V +: V]),
      .vc_consumed_o   (vc_weight_is_consumed_all[gp*V +: V]),
      .port_consumed_o (iport_weight_is_consumed_all[gp]),
      .port_weight_o   (port_weight_q_all[gp*WEIGHTw +: WEIGHTw])
    );
  end

endmodule

// File: tb/tb_swa_weight_ctrl.sv
// Bench for swa_weight_ctrl: directed round scenarios then random grants, checked against a counting model.
module tb_swa_weight_ctrl;

  localparam int V  = 4;
  localparam int P  = 5;
  localparam int WW = 4;
  localparam int PV = P * V;

  logic            clk = 1'b0;
  logic            reset;
  logic [P*WW-1:0] cfg;
  logic [PV-1:0]   req, gnt, tail;
  logic [P-1:0]    gany;
  logic [PV-1:0]   vc_o;
  logic [P-1:0]    port_o;
  logic [P*WW-1:0] wq_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: round weight, grants in round, grants per VC since last VC pulse.
  int            m_wq[P];
  int            m_pcnt[P];
  bit            m_open[P];
  int            m_vcnt[PV];
  logic [PV-1:0] e_vc;
  logic [P-1:0]  e_port;

  always #5 clk = ~clk;

  swa_weight_ctrl #(.V(V), .P(P), .WEIGHTw(WW)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .weight_cfg_all                 (cfg),
    .ivc_request_all                (req),
    .ivc_num_getting_sw_grant       (gnt),
    .any_ivc_sw_request_granted_all (gany),
    .ivc_tail_granted_all           (tail),
    .vc_weight_is_consumed_all      (vc_o),
    .iport_weight_is_consumed_all   (port_o),
    .port_weight_q_all              (wq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      m_wq[p] = 0; m_pcnt[p] = 0; m_open[p] = 1'b0;
    end
    for (int i = 0; i < PV; i++) m_vcnt[i] = 0;
    e_vc = '0;
    e_port = '0;
  endtask

  task automatic model_step();
    int w;
    e_vc = '0;
    e_port = '0;
    for (int p = 0; p < P; p++) begin
      if (gany[p]) begin
        if (!m_open[p]) begin
          w = int'(cfg[p*WW +: WW]);
          m_wq[p] = (w == 0) ? 1 : w;
          m_open[p] = 1'b1;
        end
        m_pcnt[p]++;
        if (m_pcnt[p] >= m_wq[p]) begin
          e_port[p] = 1'b1;
          m_pcnt[p] = 0;
          m_open[p] = 1'b0;
        end
        for (int v = 0; v < V; v++) begin
          if (gnt[p*V+v]) begin
            m_vcnt[p*V+v]++;
            if (tail[p*V+v] || m_vcnt[p*V+v] >= m_wq[p]) begin
              e_vc[p*V+v] = 1'b1;
              m_vcnt[p*V+v] = 0;
            end
          end
        end
      end else if (req[p*V +: V] == '0) begin
        m_pcnt[p] = 0;
        m_open[p] = 1'b0;
        for (int v = 0; v < V; v++) m_vcnt[p*V+v] = 0;
      end
    end
  endtask

  function automatic logic [P*WW-1:0] exp_wq();
    logic [P*WW-1:0] r;
    r = '0;
    for (int p = 0; p < P; p++) r[p*WW +: WW] = WW'(m_wq[p]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("vc_pulse", 32'(vc_o), 32'(e_vc));
    chk("port_pulse", 32'(port_o), 32'(e_port));
    chk("port_wq", 32'(wq_o), 32'(exp_wq()));
  endtask

  task automatic clear_inputs();
    req = '0; gnt = '0; tail = '0; gany = '0;
  endtask

  task automatic set_w(input int p, input int w);
    cfg[p*WW +: WW] = WW'(w);
  endtask

  task automatic drive(input int p, input logic [V-1:0] r, input logic [V-1:0] g, input logic [V-1:0] t);
    req[p*V +: V]  = r;
    gnt[p*V +: V]  = g;
    tail[p*V +: V] = t;
    gany[p]        = |g;
  endtask

  task automatic idle_cycle();
    clear_inputs();
    tick();
  endtask

  initial begin
    logic [V-1:0] r, g, t;
    int s, sel;

    cfg = '0;
    clear_inputs();
    model_reset();
    reset = 1'b0;
    #12;
    chk("rst_vc", 32'(vc_o), 32'd0);
    chk("rst_port", 32'(port_o), 32'd0);
    chk("rst_wq", 32'(wq_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Port 0, weight 3, IVC0 granted continuously.
    set_w(0, 3);
    for (int c = 1; c <= 9; c++) begin
      drive(0, 4'b0001, 4'b0001, 4'b0000);
      tick();
      chk("w3_port0", 32'(port_o[0]), 32'((c % 3) == 0));
      chk("w3_vc0", 32'(vc_o[0]), 32'((c % 3) == 0));
    end
    idle_cycle();

    // Weight 0 behaves as 1.
    set_w(2, 0);
    for (int c = 1; c <= 4; c++) begin
      drive(2, 4'b0100, 4'b0100, 4'b0000);
      tick();
      chk("w0_port2", 32'(port_o[2]), 32'd1);
      chk("w0_wq2", 32'(wq_o[2*WW +: WW]), 32'd1);
    end
    idle_cycle();

    // Tail on IVC1's 2nd grant ends the VC round early; port round still 4.
    set_w(1, 4);
    for (int c = 1; c <= 4; c++) begin
      drive(1, 4'b0010, 4'b0010, (c == 2) ? 4'b0010 : 4'b0000);
      tick();
      chk("tail_vc5", 32'(vc_o[5]), 32'(c == 2));
      chk("tail_port1", 32'(port_o[1]), 32'(c == 4));
    end
    idle_cycle();

    // Weight change mid-round applies from the next round.
    set_w(4, 3);
    for (int c = 1; c <= 8; c++) begin
      drive(4, 4'b1000, 4'b1000, 4'b0000);
      tick();
      if (c == 1) set_w(4, 5);
      chk("wchg_port4", 32'(port_o[4]), 32'(c == 3 || c == 8));
      chk("wchg_wq4", 32'(wq_o[4*WW +: WW]), (c <= 3) ? 32'd3 : 32'd5);
    end
    idle_cycle();

    // Request drop clears a partial round without a pulse.
    set_w(3, 4);
    for (int c = 1; c <= 2; c++) begin
      drive(3, 4'b0001, 4'b0001, 4'b0000);
      tick();
    end
    idle_cycle();
    chk("idle_port3", 32'(port_o[3]), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      drive(3, 4'b0001, 4'b0001, 4'b0000);
      tick();
      chk("idle_fresh_port3", 32'(port_o[3]), 32'(c == 4));
    end

    // Asynchronous reset mid-round.
    for (int c = 1; c <= 2; c++) begin
      drive(3, 4'b0001, 4'b0001, 4'b0000);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_vc", 32'(vc_o), 32'd0);
    chk("async_rst_port", 32'(port_o), 32'd0);
    chk("async_rst_wq", 32'(wq_o), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      drive(3, 4'b0001, 4'b0001, 4'b0000);
      tick();
      chk("post_rst_port3", 32'(port_o[3]), 32'(c == 4));
    end
    idle_cycle();

    // Random traffic on all ports.
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < P; p++) begin
        if ($urandom_range(0, 19) == 0) set_w(p, int'($urandom_range(0, 15)));
        r = V'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) r = '0;
        g = '0;
        t = '0;
        if (r != '0 && $urandom_range(0, 3) != 0) begin
          s = int'($urandom_range(0, V - 1));
          sel = -1;
          for (int k = 0; k < V; k++) begin
            if (sel < 0 && r[(s + k) % V]) sel = (s + k) % V;
          end
          g[sel] = 1'b1;
          if ($urandom_range(0, 3) == 0) t = g;
        end
        drive(p, r, g, t);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
